// File: rtl/arm_pkg.sv
// Shared definitions for the execute stage: opcode encoding, NZCV bit
// positions and the execute-stage FSM state encoding.
package arm_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_EOR  = 4'h1,
        OP_SUB  = 4'h2,
        OP_RSB  = 4'h3,
        OP_ADD  = 4'h4,
        OP_ADC  = 4'h5,
        OP_SBC  = 4'h6,
        OP_ORR  = 4'h7,
        OP_MOV  = 4'h8,
        OP_MVN  = 4'h9,
        OP_BIC  = 4'hA,
        OP_CMP  = 4'hB,
        OP_CMN  = 4'hC,
        OP_TST  = 4'hD,
        OP_MUL  = 4'hE,
        OP_UDIV = 4'hF
    } opcode_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_e;

endpackage

// File: rtl/arm_udiv.sv
// Iterative restoring unsigned divider: one quotient bit per clock, W
// iterations after start. done is asserted combinationally during the last
// iteration cycle and quotient then already carries the final value, so the
// caller can register it on the same edge that retires the divide.
module arm_udiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [CW-1:0] count;
    logic [W:0]    rem_sh;
    logic [W:0]    diff;
    logic [W-1:0]  rem_next;
    logic [W-1:0]  quo_next;

    // One restoring step: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_sh   = {rem, quo[W-1]};
        diff     = rem_sh - {1'b0, dvs};
        quo_next = {quo[W-2:0], ~diff[W]};
        rem_next = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
    end

    assign done     = busy && (count == CW'(1));
    assign quotient = quo_next;

    // Iteration registers; abort wins over everything so a flush always frees the unit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            busy  <= 1'b0;
        end else if (start) begin
            rem   <= '0;
            quo   <= dividend;
            dvs   <= divisor;
            count <= CW'(W);
            busy  <= 1'b1;
        end else if (busy) begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count - CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// ALU execute stage: single-cycle logical/arithmetic/multiply ops with NZCV
// generation, plus an optional multi-cycle unsigned divide.
// Build option: define ARM_DIV_EN to include the divider; otherwise opcode F
// is reported as undefined and in_ready is tied high.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | accepting one op per cycle, in_ready high
//   ST_DIV  | divide in flight, in_ready low until quotient is returned
module exec_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] oprand1,
    input  logic [W-1:0] oprand2,
    input  logic [3:0]   rd_addr,
    input  logic         set_flags,
    input  logic         carry_in,
    input  logic [3:0]   nzcv_in,
    output logic         out_valid,
    output logic [W-1:0] result,
    output logic [3:0]   wb_addr,
    output logic         wb_en,
    output logic [3:0]   nzcv_out,
    output logic         flags_en,
    output logic         undef
);

    import arm_pkg::*;

    opcode_e      op;
    logic         accept;
    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic         add_cin;
    logic [W:0]   sum;
    logic         add_v;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    logic         flags_req;
    logic         wb_req;
    logic         undef_op;
    logic         start_div;
    logic [3:0]   nzcv_calc;
    logic         div_done;
    logic [W-1:0] div_q;
    logic [3:0]   div_rd;

    assign op     = opcode_e'(opcode);
    assign accept = in_valid && in_ready && !flush;

    // Shared adder: subtraction is x + ~y + 1, so carry-out is NOT borrow.
    always_comb begin
        add_x   = oprand1;
        add_y   = oprand2;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_y   = ~oprand2;
                add_cin = 1'b1;
            end
            OP_RSB: begin
                add_x   = oprand2;
                add_y   = ~oprand1;
                add_cin = 1'b1;
            end
            OP_ADC: add_cin = nzcv_in[NZCV_C];
            OP_SBC: begin
                add_y   = ~oprand2;
                add_cin = nzcv_in[NZCV_C];
            end
            default: ;
        endcase
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
    assign add_v = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);

    // Result, flag sources and writeback/flag enables per opcode.
    always_comb begin
        alu_res   = '0;
        alu_c     = carry_in;
        alu_v     = nzcv_in[NZCV_V];
        flags_req = set_flags;
        wb_req    = 1'b1;
        undef_op  = 1'b0;
        start_div = 1'b0;
        case (op)
            OP_AND: alu_res = oprand1 & oprand2;
            OP_EOR: alu_res = oprand1 ^ oprand2;
            OP_ORR: alu_res = oprand1 | oprand2;
            OP_MOV: alu_res = oprand2;
            OP_MVN: alu_res = ~oprand2;
            OP_BIC: alu_res = oprand1 & ~oprand2;
            OP_TST: begin
                alu_res   = oprand1 & oprand2;
                flags_req = 1'b1;
                wb_req    = 1'b0;
            end
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = add_v;
            end
            OP_CMP, OP_CMN: begin
                alu_res   = sum[W-1:0];
                alu_c     = sum[W];
                alu_v     = add_v;
                flags_req = 1'b1;
                wb_req    = 1'b0;
            end
            OP_MUL: begin
                alu_res = oprand1 * oprand2;
                alu_c   = nzcv_in[NZCV_C];
            end
            OP_UDIV: begin
                flags_req = 1'b0;
`ifdef ARM_DIV_EN
                start_div = (oprand2 != '0);
`else
                wb_req    = 1'b0;
                undef_op  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign nzcv_calc = {alu_res[W-1], (alu_res == '0), alu_c, alu_v};

`ifdef ARM_DIV_EN
    state_e state;
    state_e next_state;
    logic   div_busy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Leave DIV on completion or flush; the busy check keeps the FSM from
    // waiting on a divider that is no longer running.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept && start_div) next_state = ST_DIV;
            ST_DIV:  if (flush || div_done || !div_busy) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign in_ready = (state == ST_IDLE);

    // Destination of the divide in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_rd <= '0;
        end else if (accept && start_div) begin
            div_rd <= rd_addr;
        end
    end

    arm_udiv #(.W(W)) u_udiv (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && start_div),
        .abort    (flush && (state == ST_DIV)),
        .dividend (oprand1),
        .divisor  (oprand2),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );
`else
    assign in_ready = 1'b1;
    assign div_done = 1'b0;
    assign div_q    = '0;
    assign div_rd   = '0;
`endif

    // Registered outputs: divide completion or a single-cycle op, never both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            wb_addr   <= '0;
            wb_en     <= 1'b0;
            nzcv_out  <= '0;
            flags_en  <= 1'b0;
            undef     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            flags_en  <= 1'b0;
            undef     <= 1'b0;
            if (div_done && !flush) begin
                out_valid <= 1'b1;
                result    <= div_q;
                wb_addr   <= div_rd;
                wb_en     <= 1'b1;
                nzcv_out  <= nzcv_in;
            end else if (accept && !start_div) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                wb_addr   <= rd_addr;
                wb_en     <= wb_req;
                flags_en  <= flags_req;
                nzcv_out  <= flags_req ? nzcv_calc : nzcv_in;
                undef     <= undef_op;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
`timescale 1ns/1ps
module tb_exec_stage;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  wb_addr;
        logic        wb_en;
        logic        flags_en;
        logic        undef;
        logic [3:0]  nzcv;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  opcode;
    logic [31:0] oprand1;
    logic [31:0] oprand2;
    logic [3:0]  rd_addr;
    logic        set_flags;
    logic        carry_in;
    logic [3:0]  nzcv_in;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  wb_addr;
    logic        wb_en;
    logic [3:0]  nzcv_out;
    logic        flags_en;
    logic        undef;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_last = -1;

    exec_stage #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .opcode    (opcode),
        .oprand1   (oprand1),
        .oprand2   (oprand2),
        .rd_addr   (rd_addr),
        .set_flags (set_flags),
        .carry_in  (carry_in),
        .nzcv_in   (nzcv_in),
        .out_valid (out_valid),
        .result    (result),
        .wb_addr   (wb_addr),
        .wb_en     (wb_en),
        .nzcv_out  (nzcv_out),
        .flags_en  (flags_en),
        .undef     (undef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Architectural reference: ARM data-processing semantics in plain integer arithmetic.
    function automatic exp_t model(bit [3:0] op, bit [31:0] a, bit [31:0] b, bit s, bit csh, bit [3:0] nz);
        exp_t    e;
        longint  u;
        longint  sg;
        longint  ci;
        bit [31:0] r;
        bit [31:0] x;
        bit [31:0] y;
        bit c, v, fl, wb, und;
        r = 0; c = csh; v = nz[0]; fl = s; wb = 1; und = 0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a ^ b;
            4'h7: r = a | b;
            4'h8: r = b;
            4'h9: r = ~b;
            4'hA: r = a & ~b;
            4'hD: begin r = a & b; fl = 1; wb = 0; end
            4'h4, 4'h5, 4'hC: begin
                ci = (op == 4'h5) ? longint'(nz[1]) : 0;
                u  = longint'(a) + longint'(b) + ci;
                sg = longint'($signed(a)) + longint'($signed(b)) + ci;
                r  = u[31:0];
                c  = (u > 64'h0000_0000_FFFF_FFFF);
                v  = (sg != longint'($signed(r)));
                if (op == 4'hC) begin fl = 1; wb = 0; end
            end
            4'h2, 4'h3, 4'h6, 4'hB: begin
                x  = (op == 4'h3) ? b : a;
                y  = (op == 4'h3) ? a : b;
                ci = (op == 4'h6) ? longint'(!nz[1]) : 0;
                u  = longint'(x) - longint'(y) - ci;
                sg = longint'($signed(x)) - longint'($signed(y)) - ci;
                r  = u[31:0];
                c  = (u >= 0);
                v  = (sg != longint'($signed(r)));
                if (op == 4'hB) begin fl = 1; wb = 0; end
            end
            4'hE: begin r = a * b; c = nz[1]; v = nz[0]; end
            default: begin
`ifdef ARM_DIV_EN
                r  = (b == 0) ? 32'h0 : a / b;
                fl = 0;
`else
                r = 0; wb = 0; fl = 0; und = 1;
`endif
            end
        endcase
        e.result   = r;
        e.wb_addr  = 0;
        e.wb_en    = wb;
        e.flags_en = fl;
        e.undef    = und;
        e.nzcv     = {r[31], (r == 0), c, v};
        e.due      = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst) begin
            if (out_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output cyc=%0d got result=%h wb_addr=%h wb_en=%b undef=%b", cyc, result, wb_addr, wb_en, undef);
                end else begin
                    e  = sb.pop_front();
                    ok = (result == e.result) && (wb_addr == e.wb_addr) && (wb_en == e.wb_en) &&
                         (flags_en == e.flags_en) && (undef == e.undef) && (cyc == e.due) &&
                         (!e.flags_en || nzcv_out == e.nzcv);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL output cyc=%0d got res=%h wa=%h wb=%b fe=%b nzcv=%b ud=%b, exp res=%h wa=%h wb=%b fe=%b nzcv=%b ud=%b due=%0d",
                                 cyc, result, wb_addr, wb_en, flags_en, nzcv_out, undef,
                                 e.result, e.wb_addr, e.wb_en, e.flags_en, e.nzcv, e.undef, e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_output cyc=%0d got none, exp res=%h due=%0d", cyc, sb[0].result, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // One driver cycle: present inputs, check in_ready, predict the response.
    task automatic step(bit v, bit [3:0] op, bit [31:0] a, bit [31:0] b, bit [3:0] rd,
                        bit s, bit csh, bit [3:0] nz, bit fl);
        exp_t e;
        bit   exp_rdy;
        bit   is_div;
        in_valid  = v;
        opcode    = op;
        oprand1   = a;
        oprand2   = b;
        rd_addr   = rd;
        set_flags = s;
        carry_in  = csh;
        nzcv_in   = nz;
        flush     = fl;
        exp_rdy   = !(cyc <= busy_last);
        n_vec++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_rdy);
        end
        if (fl && !exp_rdy) begin
            if (sb.size() > 0) void'(sb.pop_back());
            busy_last = cyc;
        end
        if (v && exp_rdy && !fl) begin
            e = model(op, a, b, s, csh, nz);
            e.wb_addr = rd;
`ifdef ARM_DIV_EN
            is_div = (op == 4'hF) && (b != 0);
`else
            is_div = 1'b0;
`endif
            e.due = cyc + (is_div ? 33 : 1);
            if (is_div) busy_last = cyc + 32;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_check();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || result !== 32'h0 || wb_addr !== 4'h0 || wb_en !== 1'b0 ||
            nzcv_out !== 4'h0 || flags_en !== 1'b0 || undef !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset got ov=%b res=%h wa=%h wb=%b nzcv=%b fe=%b ud=%b rdy=%b exp all 0, rdy 1",
                     out_valid, result, wb_addr, wb_en, nzcv_out, flags_en, undef, in_ready);
        end
        sb.delete();
        busy_last = -1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic bit [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit fl;
        rst = 1'b0; in_valid = 0; flush = 0; opcode = 0; oprand1 = 0; oprand2 = 0;
        rd_addr = 0; set_flags = 0; carry_in = 0; nzcv_in = 0;
        @(posedge clk);
        reset_check();

        // Directed corner cases.
        step(1, 4'h4, 32'h7FFF_FFFF, 32'h1, 4'd1, 1, 0, 4'b0000, 0);
        step(1, 4'hB, 32'd5, 32'd5, 4'd2, 0, 0, 4'b0000, 0);
        step(1, 4'h5, 32'hFFFF_FFFF, 32'h0, 4'd3, 1, 0, 4'b0010, 0);
        step(1, 4'h5, 32'hFFFF_FFFF, 32'h0, 4'd4, 1, 0, 4'b0010, 0);
        step(1, 4'hF, 32'd100, 32'd7, 4'd5, 1, 0, 4'b0000, 0);
        step(1, 4'hF, 32'd100, 32'd0, 4'd6, 1, 0, 4'b0000, 0);
        idle(36);
        step(1, 4'hF, 32'd100, 32'd7, 4'd7, 0, 0, 4'b0000, 0);
        idle(9);
        step(0, 4'h0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 4'h4, 32'd3, 32'd4, 4'd8, 1, 0, 4'b0000, 0);
        step(1, 4'hD, 32'hF0, 32'h0F, 4'd9, 0, 1, 4'b0001, 1);
        step(1, 4'hF, 32'd1000, 32'd3, 4'd10, 0, 0, 4'b0000, 0);
        idle(5);
        reset_check();
        idle(3);

        // Randomized stream with idle gaps, flushes and one mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) reset_check();
            fl = ($urandom_range(0, 9) == 0) && !(cyc <= busy_last);
            step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), fl);
        end
        idle(40);

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
